fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
- Pixel-sink end of the drawing pipeline: consumes the (x, y) pixel stream produced by the quad rasteriser under the screen-draw FSM.
- Clips each pixel to the framebuffer and converts it to a linear address.
- Buffers pixels in a small FIFO and writes them to framebuffer memory over a req/gnt port.
- Also performs full-screen clears, and reports completion once a drawing pass has been fully committed to memory.

Parameters:
- CORDW, 16, signed pixel coordinate width (matches draw pipeline).
- FB_W, 440, framebuffer width in pixels (400 viewport + 2×20 displacement).
- FB_H, 440, framebuffer height in pixels.
- ADDRW, 18, memory address width; must satisfy 2^ADDRW ≥ FB_W×FB_H.
- COLRW, 4, pixel colour width.
- FIFO_DEPTH, 8, pixel FIFO entries (power of 2).
- AFULL_FREE, 3, stall is asserted when free FIFO slots ≤ AFULL_FREE.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- pix_valid  in  1  pixel strobe (rasteriser "drawing").
- pix_x  in  CORDW  signed pixel X.
- pix_y  in  CORDW  signed pixel Y.
- pix_color  in  COLRW  pixel colour.
- draw_done  in  1  one-cycle pulse: upstream pass complete.
- clear_start  in  1  one-cycle pulse: request full-screen clear.
- clear_color  in  COLRW  clear colour, sampled with clear_start.
- stall  out  1  upstream must drop its output-enable while high.
- mem_req  out  1  write request.
- mem_addr  out  ADDRW  write address.
- mem_wdata  out  COLRW  write data.
- mem_gnt  in  1  write accepted this cycle (valid only when mem_req=1).
- busy  out  1  state≠IDLE, or FIFO/pipeline not empty.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky: a pixel was dropped.
- clip_cnt  out  16  saturating count of clipped pixels.

Behaviour:
- Reset: rstn synchronous, active-low; clock clk.
  - Outputs at reset: stall=0, mem_req=0, mem_addr=0, mem_wdata=0, busy=0, done=0, overflow=0, clip_cnt=0.
  - Reset also empties the FIFO and sets state to IDLE.
  - Reset mid-clear or mid-drain aborts immediately; no further mem_req.
- States:
  - IDLE: accept pixels; FIFO drains to memory.
  - CLEAR: clear counter drives the memory port.
  - DRAIN: draw_done seen; wait for pipeline and FIFO to empty.
- Stage 1 (cycle t, pix_valid=1, state IDLE or DRAIN):
  - A pixel is in range iff 0 ≤ x < FB_W and 0 ≤ y < FB_H (signed compare).
  - Out-of-range pixel: discarded; clip_cnt+1, saturating at 16'hFFFF.
  - In-range pixel: registered as addr = y×FB_W + x (truncate to ADDRW; product computed at ADDRW+1 bits), together with its colour.
- Stage 2 (cycle t+1): registered entry pushed to FIFO. mem_req is asserted at t+2 at the earliest.
- Full FIFO:
  - Stage-2 push while full with no same-cycle pop: pixel dropped, overflow←1 (cleared only by reset).
  - Push and pop in the same cycle are both legal when full.
- stall is combinational from the registered FIFO count: free slots ≤ AFULL_FREE, or state==CLEAR.
- Memory port:
  - mem_req=1 whenever FIFO is non-empty (IDLE/DRAIN), driving mem_addr/mem_wdata = FIFO head.
  - Signals stay stable until mem_gnt. Pop on mem_req & mem_gnt.
  - Writes commit in input order.
- pix_valid while in CLEAR: pixel dropped, overflow←1.
- Clear:
  - clear_start is honoured only in IDLE with FIFO and stage 1 empty; otherwise ignored, with no side effects.
  - IDLE→CLEAR: counter=0, colour latched.
  - In CLEAR: mem_req=1, mem_addr=counter, mem_wdata=latched colour. Counter increments on each gnt.
  - Grant at counter = FB_W×FB_H−1 → done pulse next cycle, state→IDLE.
- draw_done:
  - In IDLE → DRAIN. In DRAIN or CLEAR it is ignored.
  - DRAIN: when stage 1 is empty, FIFO is empty and no outstanding req → done=1 for one cycle, state→IDLE.
  - draw_done in the same cycle as a final pix_valid: the pixel is still written before done.
- clear_start and draw_done in the same IDLE cycle: clear has priority and draw_done is dropped.

Decomposition:
- Shared package fb_pkg:
  - state typedef (IDLE/CLEAR/DRAIN, 2 bits).
  - FB_W/FB_H/ADDRW defaults.
  - pixel-entry struct {addr, color}.
- One sub-module: pixel_fifo (parameterised synchronous FIFO with count output, push/pop/full/empty).

Test Plan:
- Pixel (10,3,colour 5), mem_gnt tied 1 → exactly one write: mem_req at t+2, addr=3×440+10=1330, wdata=5; busy low at t+3.
- Pixels (−1,0), (440,5), (0,440), (439,439) → clip_cnt=3, single write at addr 193599.
- mem_gnt=0 while 8 pixels are streamed → stall rises when count reaches 5. A 9th push while full sets overflow=1. Raising gnt drains 8 writes in input order.
- clear_start, colour 0xA, gnt alternating 1/0 → 193600 writes at addrs 0..193599 with data 0xA; done pulses once after the last grant. stall=1 throughout. Pixels injected mid-clear set overflow.
- 4 pixels then draw_done with gnt held 0 for 10 cycles → no done until all 4 written; done pulses 1 cycle after the last pop.
- rstn low mid-clear (counter≈100) → next cycle mem_req=0, busy=0, clip_cnt=0, overflow=0. A subsequent clear_start restarts at addr 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer pixel writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fb_pkg;

  localparam int FB_W_D  = 440;
  localparam int FB_H_D  = 440;
  localparam int ADDRW_D = 18;
  localparam int COLRW_D = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2
  } fb_state_t;

  // One buffered framebuffer write: linear address plus colour.
  typedef struct packed {
    logic [ADDRW_D-1:0] addr;
    logic [COLRW_D-1:0] color;
  } pix_ent_t;

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Framebuffer memory write port: request held stable until granted.
// Latency: n/a (signal bundle).
// Backpressure: mem_gnt low holds mem_req/mem_addr/mem_wdata.
interface fb_pixel_writer_if #(
  parameter int ADDRW = fb_pkg::ADDRW_D,
  parameter int COLRW = fb_pkg::COLRW_D
);
  logic             mem_req;
  logic [ADDRW-1:0] mem_addr;
  logic [COLRW-1:0] mem_wdata;
  logic             mem_gnt;

  modport master (output mem_req, output mem_addr, output mem_wdata, input mem_gnt);
  modport slave  (input mem_req, input mem_addr, input mem_wdata, output mem_gnt);
endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push while full is ignored unless a pop happens the same cycle.
module pixel_fifo #(
  parameter int W     = 22,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  // Storage array has no reset; contents are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fb_pixel_writer.sv
// Clips rasteriser pixels, buffers them and writes them to the framebuffer; also full-screen clear.
// Latency: pixel in at cycle t -> earliest mem_req at t+2; done one cycle after the final commit.
// Backpressure: stall when FIFO free slots <= AFULL_FREE or clearing; mem_gnt low holds the port.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int CORDW      = 16,
  parameter int FB_W       = FB_W_D,
  parameter int FB_H       = FB_H_D,
  parameter int ADDRW      = ADDRW_D,
  parameter int COLRW      = COLRW_D,
  parameter int FIFO_DEPTH = 8,
  parameter int AFULL_FREE = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    pix_valid,
  input  logic signed [CORDW-1:0] pix_x,
  input  logic signed [CORDW-1:0] pix_y,
  input  logic [COLRW-1:0]        pix_color,
  input  logic                    draw_done,
  input  logic                    clear_start,
  input  logic [COLRW-1:0]        clear_color,
  output logic                    stall,
  fb_pixel_writer_if.master       mem,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [15:0]             clip_cnt
);
  localparam int AW1 = ADDRW + 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [CORDW-1:0] W_S  = CORDW'(FB_W);
  localparam logic signed [CORDW-1:0] H_S  = CORDW'(FB_H);
  localparam logic [ADDRW-1:0]        LAST = ADDRW'(FB_W * FB_H - 1);

  fb_state_t        state;
  logic [ADDRW-1:0] clr_cnt;
  logic [COLRW-1:0] clr_color;
  logic             s1_vld;
  pix_ent_t         s1_ent;
  pix_ent_t         fifo_head;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    free_slots;
  logic             in_range, s1_load, ovf_drop, clear_ok, drain_fin;
  logic [AW1-1:0]   addr_calc;

  // Sign bit clear means non-negative; upper bounds are signed compares.
  assign in_range  = !pix_x[CORDW-1] && (pix_x < W_S) && !pix_y[CORDW-1] && (pix_y < H_S);
  assign addr_calc = AW1'($unsigned(pix_y)) * AW1'(FB_W) + AW1'($unsigned(pix_x));
  assign s1_load   = pix_valid && (state != CLEAR) && in_range;

  // While clearing, the counter owns the port and the FIFO must not pop.
  assign fifo_pop  = (state != CLEAR) && mem.mem_gnt;
  assign ovf_drop  = s1_vld && fifo_full && !(fifo_pop && !fifo_empty);
  assign clear_ok  = clear_start && !s1_vld && fifo_empty;

  // Finish decided one cycle early so done lands the cycle after the last pop.
  assign drain_fin = !s1_vld && !s1_load &&
                     (fifo_empty || (fifo_count == CW'(1) && fifo_pop));

  pixel_fifo #(.W($bits(pix_ent_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (s1_vld),
    .push_dat (s1_ent),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Stage 1 capture, clip counting and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_vld   <= 1'b0;
      s1_ent   <= '0;
      clip_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      s1_vld <= s1_load;
      if (s1_load) s1_ent <= '{addr: ADDRW_D'(addr_calc), color: COLRW_D'(pix_color)};
      if (pix_valid && (state != CLEAR) && !in_range && (clip_cnt != 16'hFFFF))
        clip_cnt <= clip_cnt + 16'd1;
      if ((pix_valid && (state == CLEAR)) || ovf_drop) overflow <= 1'b1;
    end
  end

  // Control FSM: clear sequencing, drain tracking and the done pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      clr_color <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_ok) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            clr_color <= clear_color;
          end else if (draw_done) begin
            state <= DRAIN;
          end
        end
        CLEAR: begin
          if (mem.mem_gnt) begin
            if (clr_cnt == LAST) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              clr_cnt <= clr_cnt + ADDRW'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_fin) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign free_slots    = CW'(FIFO_DEPTH) - fifo_count;
  assign stall         = (free_slots <= CW'(AFULL_FREE)) || (state == CLEAR);
  assign busy          = (state != IDLE) || s1_vld || !fifo_empty;
  assign mem.mem_req   = (state == CLEAR) || !fifo_empty;
  assign mem.mem_addr  = (state == CLEAR) ? clr_cnt :
                         (!fifo_empty ? ADDRW'(fifo_head.addr) : '0);
  assign mem.mem_wdata = (state == CLEAR) ? clr_color :
                         (!fifo_empty ? COLRW'(fifo_head.color) : '0);
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench: full-size writer for pixel/stall/drain cases, small 20x10 writer for clear/reset.
module tb_fb_pixel_writer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Full-size instance
  logic               rstn, pix_valid, draw_done, clear_start;
  logic signed [15:0] pix_x, pix_y;
  logic [3:0]         pix_color, clear_color;
  logic               stall, busy, done, overflow;
  logic [15:0]        clip_cnt;
  fb_pixel_writer_if mb ();

  fb_pixel_writer dut (
    .clk(clk), .rstn(rstn), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .draw_done(draw_done), .clear_start(clear_start),
    .clear_color(clear_color), .stall(stall), .mem(mb), .busy(busy), .done(done),
    .overflow(overflow), .clip_cnt(clip_cnt)
  );

  // Small instance (20x10 = 200 pixels) for clear sequencing
  logic               s_rstn, s_pix_valid, s_draw_done, s_clear_start;
  logic signed [15:0] s_pix_x, s_pix_y;
  logic [3:0]         s_pix_color, s_clear_color;
  logic               s_stall, s_busy, s_done, s_overflow;
  logic [15:0]        s_clip_cnt;
  fb_pixel_writer_if ms ();

  fb_pixel_writer #(.FB_W(20), .FB_H(10)) dus (
    .clk(clk), .rstn(s_rstn), .pix_valid(s_pix_valid), .pix_x(s_pix_x), .pix_y(s_pix_y),
    .pix_color(s_pix_color), .draw_done(s_draw_done), .clear_start(s_clear_start),
    .clear_color(s_clear_color), .stall(s_stall), .mem(ms), .busy(s_busy), .done(s_done),
    .overflow(s_overflow), .clip_cnt(s_clip_cnt)
  );

  typedef struct {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic [3:0]         col;
    bit                 inr;
    logic [17:0]        addr;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic big_reset();
    rstn = 1'b0; pix_valid = 1'b0; draw_done = 1'b0; clear_start = 1'b0;
    pix_x = '0; pix_y = '0; pix_color = '0; clear_color = '0; mb.mem_gnt = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic small_reset();
    s_rstn = 1'b0; s_pix_valid = 1'b0; s_draw_done = 1'b0; s_clear_start = 1'b0;
    s_pix_x = '0; s_pix_y = '0; s_pix_color = '0; s_clear_color = '0; ms.mem_gnt = 1'b0;
    tick(); tick();
    s_rstn = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_clip;
    int wr;
    int dn;
    int last;
    int stall_bad;
    int req_bad;
    int cnt;

    vecs[0]  = '{16'sd10,     16'sd3,      4'd5, 1'b1, 18'd1330};
    vecs[1]  = '{-16'sd1,     16'sd0,      4'd1, 1'b0, 18'd0};
    vecs[2]  = '{16'sd440,    16'sd5,      4'd2, 1'b0, 18'd0};
    vecs[3]  = '{16'sd0,      16'sd440,    4'd3, 1'b0, 18'd0};
    vecs[4]  = '{16'sd439,    16'sd439,    4'd7, 1'b1, 18'd193599};
    vecs[5]  = '{16'sd0,      16'sd0,      4'd1, 1'b1, 18'd0};
    vecs[6]  = '{16'sd439,    16'sd0,      4'd2, 1'b1, 18'd439};
    vecs[7]  = '{16'sd0,      16'sd439,    4'd3, 1'b1, 18'd193160};
    vecs[8]  = '{16'sd5,      -16'sd1,     4'd4, 1'b0, 18'd0};
    vecs[9]  = '{-16'sd32768, -16'sd32768, 4'd6, 1'b0, 18'd0};
    vecs[10] = '{16'sd32767,  16'sd3,      4'd9, 1'b0, 18'd0};

    // ---- reset state (checked while rstn is still low)
    small_reset();
    rstn = 1'b0; pix_valid = 1'b0; draw_done = 1'b0; clear_start = 1'b0;
    pix_x = '0; pix_y = '0; pix_color = '0; clear_color = '0; mb.mem_gnt = 1'b0;
    tick(); tick();
    chk("rst_stall",    32'(stall),        0);
    chk("rst_req",      32'(mb.mem_req),   0);
    chk("rst_addr",     32'(mb.mem_addr),  0);
    chk("rst_wdata",    32'(mb.mem_wdata), 0);
    chk("rst_busy",     32'(busy),         0);
    chk("rst_done",     32'(done),         0);
    chk("rst_overflow", 32'(overflow),     0);
    chk("rst_clip",     32'(clip_cnt),     0);
    rstn = 1'b1;

    // ---- table-driven single pixels, gnt tied high
    mb.mem_gnt = 1'b1;
    exp_clip = 0;
    for (int i = 0; i < 11; i++) begin
      pix_valid = 1'b1; pix_x = vecs[i].x; pix_y = vecs[i].y; pix_color = vecs[i].col;
      tick();
      pix_valid = 1'b0;
      chk($sformatf("v%0d_t1_req", i),  32'(mb.mem_req), 0);
      chk($sformatf("v%0d_t1_busy", i), 32'(busy), 32'(vecs[i].inr));
      if (!vecs[i].inr) exp_clip++;
      chk($sformatf("v%0d_clip", i), 32'(clip_cnt), 32'(exp_clip));
      tick();
      chk($sformatf("v%0d_t2_req", i), 32'(mb.mem_req), 32'(vecs[i].inr));
      if (vecs[i].inr) begin
        chk($sformatf("v%0d_addr", i),  32'(mb.mem_addr),  32'(vecs[i].addr));
        chk($sformatf("v%0d_wdata", i), 32'(mb.mem_wdata), 32'(vecs[i].col));
      end
      tick();
      chk($sformatf("v%0d_t3_busy", i), 32'(busy), 0);
      chk($sformatf("v%0d_t3_req", i),  32'(mb.mem_req), 0);
    end

    // ---- FIFO fill with gnt low: stall threshold, overflow, in-order drain
    big_reset();
    for (int i = 0; i < 10; i++) begin
      pix_valid = (i < 8); pix_x = 16'(i); pix_y = 16'sd0; pix_color = 4'(i + 1);
      tick();
      cnt = (i > 8) ? 8 : i;
      chk($sformatf("fill%0d_stall", i), 32'(stall), 32'(cnt >= 5));
    end
    pix_valid = 1'b0;
    chk("full_req",  32'(mb.mem_req),  1);
    chk("full_head", 32'(mb.mem_addr), 0);
    pix_valid = 1'b1; pix_x = 16'sd100; pix_color = 4'hF;
    tick();
    pix_valid = 1'b0;
    chk("ovf_before", 32'(overflow), 0);
    tick();
    chk("ovf_after", 32'(overflow), 1);
    mb.mem_gnt = 1'b1;
    wr = 0;
    for (int c = 0; c < 20; c++) begin
      if (mb.mem_req && mb.mem_gnt) begin
        chk($sformatf("drain8_addr%0d", wr),  32'(mb.mem_addr),  32'(wr));
        chk($sformatf("drain8_data%0d", wr),  32'(mb.mem_wdata), 32'(wr + 1));
        wr++;
      end
      tick();
    end
    chk("drain8_count",  32'(wr), 8);
    chk("ovf_sticky",    32'(overflow), 1);
    chk("drain8_busy",   32'(busy), 0);

    // ---- draw_done with last pixel, gnt held low, then drain
    big_reset();
    for (int k = 0; k < 4; k++) begin
      pix_valid = 1'b1; pix_x = 16'(20 + k); pix_y = 16'sd1; pix_color = 4'(k + 2);
      draw_done = (k == 3);
      tick();
    end
    pix_valid = 1'b0; draw_done = 1'b0;
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) dn++;
      tick();
    end
    chk("drain_early_done", 32'(dn), 0);
    chk("drain_busy",       32'(busy), 1);
    mb.mem_gnt = 1'b1;
    wr = 0; dn = 0; last = -10;
    for (int c = 0; c < 20; c++) begin
      if (mb.mem_req && mb.mem_gnt) begin
        chk($sformatf("drain4_addr%0d", wr), 32'(mb.mem_addr),  32'(460 + wr));
        chk($sformatf("drain4_data%0d", wr), 32'(mb.mem_wdata), 32'(wr + 2));
        wr++;
        last = c;
      end
      if (done) begin
        dn++;
        chk("drain_done_timing", 32'(c), 32'(last + 1));
        chk("drain_done_writes", 32'(wr), 4);
      end
      tick();
    end
    chk("drain4_count", 32'(wr), 4);
    chk("drain_done_cnt", 32'(dn), 1);
    chk("drain_idle_busy", 32'(busy), 0);

    // ---- full clear on the small instance, gnt alternating, pixel injected mid-clear
    small_reset();
    s_clear_color = 4'hA; s_clear_start = 1'b1;
    tick();
    s_clear_start = 1'b0;
    wr = 0; dn = 0; stall_bad = 0; req_bad = 0;
    for (int c = 0; c < 600; c++) begin
      ms.mem_gnt  = (c % 2 == 0);
      s_pix_valid = (c == 50); s_pix_x = 16'sd1; s_pix_y = 16'sd1;
      if (wr < 200) begin
        if (s_stall !== 1'b1) stall_bad++;
        if (ms.mem_req !== 1'b1) req_bad++;
      end
      if (ms.mem_req && ms.mem_gnt) begin
        chk($sformatf("clr_addr%0d", wr), 32'(ms.mem_addr),  32'(wr));
        chk($sformatf("clr_data%0d", wr), 32'(ms.mem_wdata), 32'hA);
        wr++;
      end
      if (s_done) begin
        dn++;
        chk("clr_done_after_last", 32'(wr), 200);
      end
      if (dn > 0 && !s_done) break;
      tick();
    end
    s_pix_valid = 1'b0; ms.mem_gnt = 1'b0;
    chk("clr_stall_cycles", 32'(stall_bad), 0);
    chk("clr_req_cycles",   32'(req_bad), 0);
    chk("clr_writes",       32'(wr), 200);
    chk("clr_done_cnt",     32'(dn), 1);
    chk("clr_overflow",     32'(s_overflow), 1);
    chk("clr_end_req",      32'(ms.mem_req), 0);
    chk("clr_end_busy",     32'(s_busy), 0);

    // ---- reset mid-clear, then restart
    s_pix_valid = 1'b1; s_pix_x = -16'sd1; s_pix_y = 16'sd0;
    tick();
    s_pix_valid = 1'b0;
    chk("pre_rst_clip", 32'(s_clip_cnt), 1);
    tick();
    s_clear_color = 4'h3; s_clear_start = 1'b1;
    tick();
    s_clear_start = 1'b0;
    ms.mem_gnt = 1'b1;
    for (int c = 0; c < 100; c++) tick();
    chk("pre_rst_addr", 32'(ms.mem_addr), 100);
    s_rstn = 1'b0;
    tick();
    chk("mid_rst_req",  32'(ms.mem_req), 0);
    chk("mid_rst_busy", 32'(s_busy), 0);
    chk("mid_rst_clip", 32'(s_clip_cnt), 0);
    chk("mid_rst_ovf",  32'(s_overflow), 0);
    chk("mid_rst_stall", 32'(s_stall), 0);
    s_rstn = 1'b1; ms.mem_gnt = 1'b0;
    tick();
    chk("post_rst_req", 32'(ms.mem_req), 0);
    s_clear_color = 4'h6; s_clear_start = 1'b1;
    tick();
    s_clear_start = 1'b0;
    chk("restart_req",  32'(ms.mem_req), 1);
    chk("restart_addr", 32'(ms.mem_addr), 0);
    chk("restart_data", 32'(ms.mem_wdata), 6);
    ms.mem_gnt = 1'b1;
    tick();
    chk("restart_addr1", 32'(ms.mem_addr), 1);
    s_rstn = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
